frame_sequencer: RTL and testbench
==================================

Name: frame_sequencer

Overview:
- Top-level controller for one binary-image frame through the median filter and histogram datapath.
- Owns the binary image memory port and arbitrates it between the pixel loader (write phase) and the filter engine (filter phase).
- Sequences filter init, start and completion, then drives the histogram readout and forwards the per-column and per-row histogram beats with bin indices.
- Sits between the host/camera interface and the filtering top level.

Parameters:
X_SIZE, 240, image columns (outer raster index)
Y_SIZE, 180, image rows (inner raster index)
ADDR_W, 8, memory x/y address width
HIST_W, 8, histogram bin value width
TIMEOUT, 4300000, max cycles in FILTER before error

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-low reset
frameReq  in  1  pulse, start a new frame
loadValid  in  1  pixel valid from loader
loadData  in  1  binary pixel
loadReady  out  1  sequencer accepts pixel
memXAddr  out  ADDR_W  binary memory x address
memYAddr  out  ADDR_W  binary memory y address
memWrite  out  1  binary memory write enable
memData  out  1  binary memory write data
fltXAddr  in  ADDR_W  filter-requested x address
fltYAddr  in  ADDR_W  filter-requested y address
fltWrite  in  1  filter-requested write enable
filterInit  out  1  one-cycle init pulse to filter
filterStart  out  1  filter run level
fullImageDone  in  1  filter completion
readHistogram  out  1  histogram readout enable
xValid  in  1  x histogram beat valid
xHistIn  in  HIST_W  x histogram value
yValid  in  1  y histogram beat valid
yHistIn  in  HIST_W  y histogram value
xHistOut  out  HIST_W  registered x bin value
xBin  out  ADDR_W  x bin index
xOutValid  out  1  x output valid
yHistOut  out  HIST_W  registered y bin value
yBin  out  ADDR_W  y bin index
yOutValid  out  1  y output valid
busy  out  1  frame in progress
frameDone  out  1  one-cycle completion pulse
timeoutErr  out  1  sticky filter timeout flag

Behaviour:
- Reset (reset=0 at a clk edge): state IDLE, all outputs 0, all counters 0. The error flag clears. Applies mid-frame; the frame is abandoned, with no frameDone.
- States: IDLE, INIT, LOAD, START, FILTER, HIST, DONE, ERR.
- IDLE: busy=0. frameReq=1 -> INIT. frameReq in any other state is ignored, except in ERR.
- INIT: filterInit=1 for exactly one cycle, busy=1, pixel counters cleared. Next state is LOAD.
- LOAD:
  - loadReady=1. memXAddr/memYAddr = (xCnt,yCnt), memWrite=loadValid, memData=loadData, combinational from counters.
  - On loadValid: yCnt increments. At yCnt=Y_SIZE-1 it wraps to 0 and xCnt increments.
  - Acceptance of (X_SIZE-1,Y_SIZE-1) -> START. Gaps in loadValid stall with no write.
- START: filterStart=1 (one cycle), then FILTER.
- FILTER:
  - filterStart=1. The memory port is muxed to fltXAddr/fltYAddr/fltWrite. memData=0 and loadReady=0.
  - The timeout counter increments each cycle.
  - fullImageDone=1 -> HIST next cycle, filterStart=0 from that cycle.
  - Counter reaching TIMEOUT first -> ERR.
  - fullImageDone and timeout in the same cycle: done wins.
- HIST:
  - readHistogram=1. The x and y channels are independent.
  - On xValid with xCnt<X_SIZE: next cycle xOutValid=1, xHistOut=xHistIn, xBin=xCnt; xCnt increments. The y channel behaves identically with Y_SIZE.
  - Beats beyond the count are dropped. Simultaneous x and y beats are both forwarded.
  - Once xCnt=X_SIZE and yCnt=Y_SIZE, go to DONE. The last output beat is visible in the DONE cycle.
  - readHistogram drops on entry to DONE.
- DONE: frameDone=1 for one cycle, busy=1, then IDLE.
- ERR:
  - timeoutErr=1 (sticky), filterStart=0, readHistogram=0, busy=0.
  - frameReq -> clears timeoutErr, goes to INIT.
- Outside LOAD and FILTER: memWrite=0 and addresses are 0.
- Output valids are 0 in every state except HIST and DONE.

Test Plan:
- Reset held 5 cycles mid-LOAD -> all outputs 0, state IDLE, a subsequent frameReq restarts at pixel (0,0).
- frameReq, then 43200 contiguous loadValid beats -> filterInit is a single-cycle pulse, and the write addresses sequence (0,0),(0,1)..(0,179),(1,0)..(239,179). START is reached the cycle after the last beat.
- Loader inserts random gaps (loadValid=0 on 30% of cycles) -> exactly 43200 memWrite cycles with no address skipped.
- FILTER phase: the filter drives fltXAddr=0x12, fltYAddr=0x34, fltWrite=1 -> memXAddr=0x12, memYAddr=0x34, memWrite=1. fullImageDone -> filterStart low and readHistogram high on the next cycle.
- HIST: inject 240 xValid and 180 yValid beats, overlapping and with gaps, plus 3 extra x beats -> 240/180 output beats with bins 0..239/0..179, extras dropped, one frameDone pulse.
- TIMEOUT set to 100 and fullImageDone held low -> timeoutErr=1 at cycle 100 of FILTER and busy=0. frameReq clears the error and re-enters INIT.

Source files
------------

// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
//
// Top-level controller for one binary-image frame through the median filter
// and histogram datapath. Owns the binary image memory port: during LOAD the
// pixel loader writes the frame in raster order (x outer, y inner); during
// FILTER the port is handed to the filter engine. After the filter reports
// completion the sequencer enables histogram readout and forwards the x and
// y histogram beats, tagged with their bin index, as registered outputs.
//
// State table
//   state  | meaning
//   IDLE   | waiting for frameReq
//   INIT   | one-cycle filterInit pulse, pixel counters cleared
//   LOAD   | accepting loader pixels into the binary memory
//   START  | first filterStart cycle, timeout counter cleared
//   FILTER | filter owns the memory port, timeout counter running
//   HIST   | readHistogram high, x/y beats forwarded with bin indices
//   DONE   | one-cycle frameDone pulse
//   ERR    | filter timed out; sticky timeoutErr until the next frameReq
//
// Ports
//   clk, reset                    system clock, synchronous active-low reset
//   frameReq                      start a new frame (IDLE or ERR only)
//   loadValid/loadData/loadReady  pixel loader handshake
//   memXAddr/memYAddr/memWrite/memData  binary image memory port
//   fltXAddr/fltYAddr/fltWrite    filter-side memory requests
//   filterInit/filterStart/fullImageDone  filter control
//   readHistogram                 histogram readout enable
//   xValid/xHistIn, yValid/yHistIn  incoming histogram beats
//   xHistOut/xBin/xOutValid, yHistOut/yBin/yOutValid  forwarded beats
//   busy/frameDone/timeoutErr     status
// -----------------------------------------------------------------------------
module frame_sequencer #(
    parameter int X_SIZE  = 240,
    parameter int Y_SIZE  = 180,
    parameter int ADDR_W  = 8,
    parameter int HIST_W  = 8,
    parameter int TIMEOUT = 4300000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frameReq,
    input  logic              loadValid,
    input  logic              loadData,
    output logic              loadReady,
    output logic [ADDR_W-1:0] memXAddr,
    output logic [ADDR_W-1:0] memYAddr,
    output logic              memWrite,
    output logic              memData,
    input  logic [ADDR_W-1:0] fltXAddr,
    input  logic [ADDR_W-1:0] fltYAddr,
    input  logic              fltWrite,
    output logic              filterInit,
    output logic              filterStart,
    input  logic              fullImageDone,
    output logic              readHistogram,
    input  logic              xValid,
    input  logic [HIST_W-1:0] xHistIn,
    input  logic              yValid,
    input  logic [HIST_W-1:0] yHistIn,
    output logic [HIST_W-1:0] xHistOut,
    output logic [ADDR_W-1:0] xBin,
    output logic              xOutValid,
    output logic [HIST_W-1:0] yHistOut,
    output logic [ADDR_W-1:0] yBin,
    output logic              yOutValid,
    output logic              busy,
    output logic              frameDone,
    output logic              timeoutErr
);

    // One extra bit so the histogram counters can hold X_SIZE / Y_SIZE
    // themselves, which marks a channel as complete.
    localparam int CNT_W = ADDR_W + 1;
    localparam int TO_W  = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] X_LAST = CNT_W'(X_SIZE - 1);
    localparam logic [CNT_W-1:0] Y_LAST = CNT_W'(Y_SIZE - 1);
    localparam logic [CNT_W-1:0] X_FULL = CNT_W'(X_SIZE);
    localparam logic [CNT_W-1:0] Y_FULL = CNT_W'(Y_SIZE);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_LOAD,
        S_START,
        S_FILTER,
        S_HIST,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    // Pixel counters during LOAD, histogram bin counters during HIST.
    logic [CNT_W-1:0]  r_x_cnt;
    logic [CNT_W-1:0]  r_y_cnt;
    logic [TO_W-1:0]   r_to_cnt;

    logic [HIST_W-1:0] r_x_hist;
    logic [HIST_W-1:0] r_y_hist;
    logic [ADDR_W-1:0] r_x_bin;
    logic [ADDR_W-1:0] r_y_bin;
    logic              r_x_vld;
    logic              r_y_vld;

    logic              w_load_take;
    logic              w_load_last;
    logic              w_timeout;
    logic              w_x_take;
    logic              w_y_take;
    logic [CNT_W-1:0]  w_x_cnt_hist;
    logic [CNT_W-1:0]  w_y_cnt_hist;

    assign w_load_take = (r_state == S_LOAD) && loadValid;
    assign w_load_last = w_load_take && (r_x_cnt == X_LAST) && (r_y_cnt == Y_LAST);

    // r_to_cnt holds the number of completed FILTER cycles, so it equals
    // TIMEOUT-1 during the TIMEOUT-th FILTER cycle.
    assign w_timeout = (r_to_cnt == TO_LAST);

    assign w_x_take = (r_state == S_HIST) && xValid && (r_x_cnt < X_FULL);
    assign w_y_take = (r_state == S_HIST) && yValid && (r_y_cnt < Y_FULL);

    // Post-beat counts decide the HIST exit, so the final forwarded beat
    // lands in the DONE cycle rather than one cycle later.
    assign w_x_cnt_hist = r_x_cnt + CNT_W'(w_x_take);
    assign w_y_cnt_hist = r_y_cnt + CNT_W'(w_y_take);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (frameReq) w_state_next = S_INIT;
            S_INIT:   w_state_next = S_LOAD;
            S_LOAD:   if (w_load_last) w_state_next = S_START;
            S_START:  w_state_next = S_FILTER;
            S_FILTER: begin
                // Completion takes priority over a coincident timeout.
                if (fullImageDone)  w_state_next = S_HIST;
                else if (w_timeout) w_state_next = S_ERR;
            end
            S_HIST:   if ((w_x_cnt_hist == X_FULL) && (w_y_cnt_hist == Y_FULL))
                          w_state_next = S_DONE;
            S_DONE:   w_state_next = S_IDLE;
            S_ERR:    if (frameReq) w_state_next = S_INIT;
            default:  w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        loadReady     = 1'b0;
        memXAddr      = '0;
        memYAddr      = '0;
        memWrite      = 1'b0;
        memData       = 1'b0;
        filterInit    = 1'b0;
        filterStart   = 1'b0;
        readHistogram = 1'b0;
        busy          = 1'b0;
        frameDone     = 1'b0;
        timeoutErr    = 1'b0;
        case (r_state)
            S_INIT: begin
                busy       = 1'b1;
                filterInit = 1'b1;
            end
            S_LOAD: begin
                busy      = 1'b1;
                loadReady = 1'b1;
                memXAddr  = r_x_cnt[ADDR_W-1:0];
                memYAddr  = r_y_cnt[ADDR_W-1:0];
                memWrite  = loadValid;
                memData   = loadData;
            end
            S_START: begin
                busy        = 1'b1;
                filterStart = 1'b1;
            end
            S_FILTER: begin
                busy        = 1'b1;
                filterStart = 1'b1;
                memXAddr    = fltXAddr;
                memYAddr    = fltYAddr;
                memWrite    = fltWrite;
            end
            S_HIST: begin
                busy          = 1'b1;
                readHistogram = 1'b1;
            end
            S_DONE: begin
                busy      = 1'b1;
                frameDone = 1'b1;
            end
            S_ERR: begin
                timeoutErr = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_x_cnt  <= '0;
            r_y_cnt  <= '0;
            r_to_cnt <= '0;
            r_x_hist <= '0;
            r_y_hist <= '0;
            r_x_bin  <= '0;
            r_y_bin  <= '0;
            r_x_vld  <= 1'b0;
            r_y_vld  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_x_vld <= w_x_take;
            r_y_vld <= w_y_take;
            if (w_x_take) begin
                r_x_hist <= xHistIn;
                r_x_bin  <= r_x_cnt[ADDR_W-1:0];
            end
            if (w_y_take) begin
                r_y_hist <= yHistIn;
                r_y_bin  <= r_y_cnt[ADDR_W-1:0];
            end
            case (r_state)
                S_INIT: begin
                    r_x_cnt <= '0;
                    r_y_cnt <= '0;
                end
                S_LOAD: begin
                    if (loadValid) begin
                        if (r_y_cnt == Y_LAST) begin
                            r_y_cnt <= '0;
                            r_x_cnt <= r_x_cnt + CNT_W'(1);
                        end else begin
                            r_y_cnt <= r_y_cnt + CNT_W'(1);
                        end
                    end
                end
                S_START: begin
                    r_x_cnt  <= '0;
                    r_y_cnt  <= '0;
                    r_to_cnt <= '0;
                end
                S_FILTER: begin
                    r_to_cnt <= r_to_cnt + TO_W'(1);
                end
                S_HIST: begin
                    r_x_cnt <= w_x_cnt_hist;
                    r_y_cnt <= w_y_cnt_hist;
                end
                default: ;
            endcase
        end
    end

    assign xHistOut  = r_x_hist;
    assign xBin      = r_x_bin;
    assign xOutValid = r_x_vld;
    assign yHistOut  = r_y_hist;
    assign yBin      = r_y_bin;
    assign yOutValid = r_y_vld;

endmodule

// File: tb/tb_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_sequencer
//
// Drives frames through frame_sequencer with a reduced image geometry so
// several complete frames (contiguous load, gapped load, timeout, completion
// on the timeout cycle) fit in a short run. Expected values come from a
// pixel-index model (address = index / rows, index % rows) and per-channel
// accepted-beat counts for the histogram readout.
// -----------------------------------------------------------------------------
module tb_frame_sequencer;

    localparam int X_SIZE  = 32;
    localparam int Y_SIZE  = 20;
    localparam int ADDR_W  = 8;
    localparam int HIST_W  = 8;
    localparam int TIMEOUT = 100;
    localparam int NPIX    = X_SIZE * Y_SIZE;

    logic              clk;
    logic              reset;
    logic              frameReq;
    logic              loadValid;
    logic              loadData;
    logic              loadReady;
    logic [ADDR_W-1:0] memXAddr;
    logic [ADDR_W-1:0] memYAddr;
    logic              memWrite;
    logic              memData;
    logic [ADDR_W-1:0] fltXAddr;
    logic [ADDR_W-1:0] fltYAddr;
    logic              fltWrite;
    logic              filterInit;
    logic              filterStart;
    logic              fullImageDone;
    logic              readHistogram;
    logic              xValid;
    logic [HIST_W-1:0] xHistIn;
    logic              yValid;
    logic [HIST_W-1:0] yHistIn;
    logic [HIST_W-1:0] xHistOut;
    logic [ADDR_W-1:0] xBin;
    logic              xOutValid;
    logic [HIST_W-1:0] yHistOut;
    logic [ADDR_W-1:0] yBin;
    logic              yOutValid;
    logic              busy;
    logic              frameDone;
    logic              timeoutErr;

    int n_chk  = 0;
    int n_fail = 0;

    frame_sequencer #(
        .X_SIZE (X_SIZE),
        .Y_SIZE (Y_SIZE),
        .ADDR_W (ADDR_W),
        .HIST_W (HIST_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .frameReq     (frameReq),
        .loadValid    (loadValid),
        .loadData     (loadData),
        .loadReady    (loadReady),
        .memXAddr     (memXAddr),
        .memYAddr     (memYAddr),
        .memWrite     (memWrite),
        .memData      (memData),
        .fltXAddr     (fltXAddr),
        .fltYAddr     (fltYAddr),
        .fltWrite     (fltWrite),
        .filterInit   (filterInit),
        .filterStart  (filterStart),
        .fullImageDone(fullImageDone),
        .readHistogram(readHistogram),
        .xValid       (xValid),
        .xHistIn      (xHistIn),
        .yValid       (yValid),
        .yHistIn      (yHistIn),
        .xHistOut     (xHistOut),
        .xBin         (xBin),
        .xOutValid    (xOutValid),
        .yHistOut     (yHistOut),
        .yBin         (yBin),
        .yOutValid    (yOutValid),
        .busy         (busy),
        .frameDone    (frameDone),
        .timeoutErr   (timeoutErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed time limit reached, expected test end");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_ctl"}, 32'({busy, loadReady, memWrite, memData, filterInit,
                                     filterStart, readHistogram, xOutValid, yOutValid,
                                     frameDone, timeoutErr}), 0);
        check_eq({tag, "_addr"}, 32'({memXAddr, memYAddr, xBin, yBin}), 0);
        check_eq({tag, "_hist"}, 32'({xHistOut, yHistOut}), 0);
    endtask

    // Issue a frameReq pulse; the cycle after it must be the lone filterInit cycle.
    task automatic start_frame(input string tag);
        @(negedge clk);
        frameReq = 1'b1;
        #1;
        check_eq({tag, "_pre_init"}, 32'(filterInit), 0);
        @(negedge clk);
        frameReq = 1'b0;
        #1;
        check_eq({tag, "_init"}, 32'(filterInit), 1);
        check_eq({tag, "_init_busy"}, 32'(busy), 1);
        check_eq({tag, "_init_err"}, 32'(timeoutErr), 0);
        check_eq({tag, "_init_ready"}, 32'(loadReady), 0);
    endtask

    // Feed pixels until n_beats are accepted; gap_pct is the chance of an idle cycle.
    task automatic do_load(input int gap_pct, input int n_beats);
        int p;
        int cyc;
        int writes;
        p = 0;
        cyc = 0;
        writes = 0;
        while (p < n_beats && cyc < 20 * NPIX) begin
            @(negedge clk);
            loadValid = (32'($urandom_range(99)) >= 32'(gap_pct));
            loadData  = 1'($urandom);
            #1;
            cyc++;
            check_eq("ld_ready", 32'(loadReady), 1);
            check_eq("ld_init", 32'(filterInit), 0);
            check_eq("ld_xaddr", 32'(memXAddr), 32'(p / Y_SIZE));
            check_eq("ld_yaddr", 32'(memYAddr), 32'(p % Y_SIZE));
            check_eq("ld_we", 32'(memWrite), 32'(loadValid));
            if (memWrite) writes++;
            if (loadValid) begin
                check_eq("ld_data", 32'(memData), 32'(loadData));
                p++;
            end
        end
        check_eq("ld_beats", 32'(p), 32'(n_beats));
        check_eq("ld_writes", 32'(writes), 32'(n_beats));
    endtask

    // The cycle right after the final pixel must be START.
    task automatic check_start(input string tag);
        @(negedge clk);
        loadValid = 1'b0;
        #1;
        check_eq({tag, "_start_fs"}, 32'(filterStart), 1);
        check_eq({tag, "_start_ready"}, 32'(loadReady), 0);
        check_eq({tag, "_start_busy"}, 32'(busy), 1);
    endtask

    // n_cycles FILTER cycles with filter-driven port traffic, then fullImageDone.
    task automatic do_filter(input int n_cycles);
        for (int i = 0; i <= n_cycles; i++) begin
            @(negedge clk);
            if (i == 0) begin
                fltXAddr = 8'h12;
                fltYAddr = 8'h34;
                fltWrite = 1'b1;
            end else begin
                fltXAddr = 8'($urandom);
                fltYAddr = 8'($urandom);
                fltWrite = 1'($urandom);
            end
            fullImageDone = (i == n_cycles);
            #1;
            check_eq("flt_xaddr", 32'(memXAddr), 32'(fltXAddr));
            check_eq("flt_yaddr", 32'(memYAddr), 32'(fltYAddr));
            check_eq("flt_we", 32'(memWrite), 32'(fltWrite));
            check_eq("flt_data", 32'(memData), 0);
            check_eq("flt_ready", 32'(loadReady), 0);
            check_eq("flt_fs", 32'(filterStart), 1);
            check_eq("flt_rh", 32'(readHistogram), 0);
        end
        @(negedge clk);
        fullImageDone = 1'b0;
        fltWrite = 1'b1;
        fltXAddr = 8'h55;
        #1;
        check_eq("hist_entry_fs", 32'(filterStart), 0);
        check_eq("hist_entry_rh", 32'(readHistogram), 1);
        check_eq("hist_entry_we", 32'(memWrite), 0);
        check_eq("hist_entry_xaddr", 32'(memXAddr), 0);
        fltWrite = 1'b0;
    endtask

    // Histogram readout with overlapping random beats and 3 surplus x beats,
    // compared against per-channel accepted-beat bookkeeping.
    task automatic do_hist();
        int xs, ys, xa, ya, xo, yo, cyc;
        logic exp_xv, exp_yv, exp_done, done_seen, xv, yv, was_full;
        logic [ADDR_W-1:0] exp_xbin, exp_ybin;
        logic [HIST_W-1:0] exp_xval, exp_yval;
        xs = 0; ys = 0; xa = 0; ya = 0; xo = 0; yo = 0; cyc = 0;
        exp_xv = 1'b0; exp_yv = 1'b0; exp_done = 1'b0; done_seen = 1'b0;
        exp_xbin = '0; exp_ybin = '0; exp_xval = '0; exp_yval = '0;
        while (!done_seen && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            xv = (xs < X_SIZE + 3) && ($urandom_range(99) < 80);
            yv = ((ys < Y_SIZE - 1) && ($urandom_range(99) < 40)) ||
                 ((ys == Y_SIZE - 1) && (xs == X_SIZE + 3));
            xValid  = xv;
            yValid  = yv;
            xHistIn = 8'($urandom);
            yHistIn = 8'($urandom);
            #1;
            check_eq("h_xvalid", 32'(xOutValid), 32'(exp_xv));
            check_eq("h_yvalid", 32'(yOutValid), 32'(exp_yv));
            if (exp_xv) begin
                check_eq("h_xbin", 32'(xBin), 32'(exp_xbin));
                check_eq("h_xval", 32'(xHistOut), 32'(exp_xval));
            end
            if (exp_yv) begin
                check_eq("h_ybin", 32'(yBin), 32'(exp_ybin));
                check_eq("h_yval", 32'(yHistOut), 32'(exp_yval));
            end
            if (xOutValid) xo++;
            if (yOutValid) yo++;
            check_eq("h_done", 32'(frameDone), 32'(exp_done));
            check_eq("h_rh", 32'(readHistogram), 32'(!exp_done));
            check_eq("h_busy", 32'(busy), 1);
            if (exp_done) done_seen = 1'b1;
            was_full = (xa == X_SIZE) && (ya == Y_SIZE);
            if (xv) xs++;
            if (yv) ys++;
            exp_xv = 1'b0;
            exp_yv = 1'b0;
            if (!exp_done && xv && xa < X_SIZE) begin
                exp_xv = 1'b1; exp_xbin = 8'(xa); exp_xval = xHistIn; xa++;
            end
            if (!exp_done && yv && ya < Y_SIZE) begin
                exp_yv = 1'b1; exp_ybin = 8'(ya); exp_yval = yHistIn; ya++;
            end
            exp_done = !was_full && (xa == X_SIZE) && (ya == Y_SIZE);
        end
        check_eq("h_done_seen", 32'(done_seen), 1);
        @(negedge clk);
        xValid = 1'b0;
        yValid = 1'b0;
        #1;
        check_eq("h_post_done", 32'(frameDone), 0);
        check_eq("h_post_busy", 32'(busy), 0);
        check_eq("h_post_xv", 32'(xOutValid), 0);
        check_eq("h_post_yv", 32'(yOutValid), 0);
        check_eq("h_xcount", 32'(xo), 32'(X_SIZE));
        check_eq("h_ycount", 32'(yo), 32'(Y_SIZE));
        check_eq("h_xsent", 32'(xs), 32'(X_SIZE + 3));
    endtask

    task automatic apply_reset(input string tag, input int n);
        @(negedge clk);
        reset = 1'b0;
        loadValid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            check_quiet(tag);
        end
        reset = 1'b1;
    endtask

    initial begin
        int cnt;
        reset = 1'b0; frameReq = 1'b0; loadValid = 1'b0; loadData = 1'b0;
        fltXAddr = '0; fltYAddr = '0; fltWrite = 1'b0; fullImageDone = 1'b0;
        xValid = 1'b0; yValid = 1'b0; xHistIn = '0; yHistIn = '0;

        apply_reset("por", 3);

        // Frame abandoned by a reset held 5 cycles mid-LOAD.
        start_frame("f1");
        do_load(0, 100);
        apply_reset("midload", 5);

        // Gapped load, restart at pixel (0,0), then filter and histogram.
        start_frame("f2");
        do_load(30, NPIX);
        check_start("f2");
        do_filter(8);
        do_hist();

        // Contiguous load, filter never completes -> timeout.
        start_frame("f3");
        do_load(0, NPIX);
        check_start("f3");
        cnt = 0;
        for (int i = 0; i < TIMEOUT + 10; i++) begin
            @(negedge clk);
            #1;
            if (timeoutErr) break;
            if (filterStart) cnt++;
        end
        check_eq("to_cycles", 32'(cnt), 32'(TIMEOUT));
        check_eq("to_err", 32'(timeoutErr), 1);
        check_eq("to_busy", 32'(busy), 0);
        check_eq("to_fs", 32'(filterStart), 0);
        repeat (3) @(negedge clk);
        #1;
        check_eq("to_sticky", 32'(timeoutErr), 1);
        check_eq("to_sticky_rh", 32'(readHistogram), 0);

        // frameReq leaves ERR; completion on the timeout cycle itself wins.
        start_frame("f4");
        do_load(0, NPIX);
        check_start("f4");
        for (int k = 1; k <= TIMEOUT; k++) begin
            @(negedge clk);
            fullImageDone = (k == TIMEOUT);
            #1;
            check_eq("dw_fs", 32'(filterStart), 1);
        end
        @(negedge clk);
        fullImageDone = 1'b0;
        #1;
        check_eq("dw_rh", 32'(readHistogram), 1);
        check_eq("dw_err", 32'(timeoutErr), 0);
        apply_reset("hist_rst", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
